wed_fetch_control: RTL

- Sequences the single Work Element Descriptor (WED) fetch at job start.
- On start, issues one 128-byte read command for the WED effective address and collects the two 64-byte buffer-write halves returned for that tag.
- Maps the raw cacheline into the WED_request structure, applying per-field endianness swaps, and presents it with a valid flag to the rest of the AFU.
- Sits between the job-control logic and the command/response/buffer arbiter. Handles retry of flushed/paged responses, a response timeout, and abort when the job is disabled.

---
 rtl/wed_fetch_control.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/wed_fetch_control.sv
// WED fetch sequencer: issues one 128-byte read for the WED, collects both buffer-write
// halves, retries flushed/paged responses and presents the endian-swapped WED_request.
module wed_fetch_control #(
   parameter int unsigned      TAG_W          = 8,
   parameter logic [TAG_W-1:0] WED_TAG        = '0,
   parameter int unsigned      MAX_RETRIES    = 3,
   parameter int unsigned      TIMEOUT_CYCLES = 4096
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enabled_in,
   input  logic             start_in,
   input  logic [63:0]      wed_address_in,
   input  logic             cmd_ready_in,
   output logic             cmd_valid_out,
   output logic [TAG_W-1:0] cmd_tag_out,
   output logic [63:0]      cmd_address_out,
   output logic [11:0]      cmd_size_out,
   input  logic             rsp_valid_in,
   input  logic [TAG_W-1:0] rsp_tag_in,
   input  logic [7:0]       rsp_code_in,
   input  logic             bufw_valid_in,
   input  logic [TAG_W-1:0] bufw_tag_in,
   input  logic [5:0]       bufw_ad_in,
   input  logic [511:0]     bufw_data_in,
   output logic             wed_valid_out,
   output logic [63:0]      wed_address_out,
   output logic [1023:0]    wed_out,
   output logic             busy_out,
   output logic             error_out,
   output logic [7:0]       error_code_out
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);
   localparam logic [7:0] RSP_DONE    = 8'h00;
   localparam logic [7:0] RSP_FLUSHED = 8'h06;
   localparam logic [7:0] RSP_PAGED   = 8'h0A;

   typedef enum logic [2:0] {
      StReset, StIdle, StReq, StWaiting, StReadData, StDoneReq
   } state_e;

   state_e            r_state;
   logic              r_cmd_valid;
   logic [63:0]       r_addr;
   logic [RT_W-1:0]   r_retries;
   logic [TO_W-1:0]   r_timeout;
   logic [1:0]        r_half;
   logic [1023:0]     r_line;
   logic              r_wed_valid;
   logic [63:0]       r_wed_address;
   logic [1023:0]     r_wed;
   logic              r_busy;
   logic              r_error;
   logic [7:0]        r_error_code;

   logic              w_bufw_hit;
   logic              w_rsp_hit;
   logic              w_have0;
   logic              w_have1;
   logic              w_retryable;
   logic [1023:0]     w_swapped;
   logic              w_unused_ad;

   assign w_unused_ad = ^bufw_ad_in[5:1];

   // The enable gate drops the request in the same cycle the job is disabled.
   assign cmd_valid_out   = r_cmd_valid & enabled_in;
   assign cmd_tag_out     = WED_TAG;
   assign cmd_address_out = r_addr;
   assign cmd_size_out    = 12'd128;
   assign wed_valid_out   = r_wed_valid;
   assign wed_address_out = r_wed_address;
   assign wed_out         = r_wed;
   assign busy_out        = r_busy;
   assign error_out       = r_error;
   assign error_code_out  = r_error_code;

   assign w_bufw_hit  = bufw_valid_in && (bufw_tag_in == WED_TAG);
   assign w_rsp_hit   = rsp_valid_in && (rsp_tag_in == WED_TAG);
   assign w_have0     = r_half[0] | (w_bufw_hit & ~bufw_ad_in[0]);
   assign w_have1     = r_half[1] | (w_bufw_hit & bufw_ad_in[0]);
   assign w_retryable = (rsp_code_in == RSP_FLUSHED) || (rsp_code_in == RSP_PAGED);

   // Byte-swap each field in place: three 32-bit words, fourteen 64-bit words, one 32-bit word.
   always_comb begin
      w_swapped = '0;
      for (int w = 0; w < 3; w++) begin
         for (int b = 0; b < 4; b++) begin
            w_swapped[32*w + 8*b +: 8] = r_line[32*w + 8*(3-b) +: 8];
         end
      end
      for (int w = 0; w < 14; w++) begin
         for (int b = 0; b < 8; b++) begin
            w_swapped[96 + 64*w + 8*b +: 8] = r_line[96 + 64*w + 8*(7-b) +: 8];
         end
      end
      for (int b = 0; b < 4; b++) begin
         w_swapped[992 + 8*b +: 8] = r_line[992 + 8*(3-b) +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= StReset;
         r_cmd_valid   <= 1'b0;
         r_addr        <= '0;
         r_retries     <= '0;
         r_timeout     <= '0;
         r_half        <= '0;
         r_line        <= '0;
         r_wed_valid   <= 1'b0;
         r_wed_address <= '0;
         r_wed         <= '0;
         r_busy        <= 1'b0;
         r_error       <= 1'b0;
         r_error_code  <= '0;
      end else if (r_state != StReset && !enabled_in) begin
         r_state       <= StIdle;
         r_cmd_valid   <= 1'b0;
         r_addr        <= '0;
         r_wed_valid   <= 1'b0;
         r_wed_address <= '0;
         r_wed         <= '0;
         r_busy        <= 1'b0;
         r_error       <= 1'b0;
         r_error_code  <= '0;
      end else begin
         case (r_state)
            StReset: r_state <= StIdle;
            StIdle: begin
               if (start_in && !r_error) begin
                  r_addr      <= wed_address_in;
                  r_retries   <= '0;
                  r_half      <= '0;
                  r_wed_valid <= 1'b0;
                  r_cmd_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= StReq;
               end
            end
            StReq: begin
               if (cmd_valid_out && cmd_ready_in) begin
                  r_cmd_valid <= 1'b0;
                  r_timeout   <= '0;
                  r_state     <= StWaiting;
               end
            end
            StWaiting: begin
               if (w_bufw_hit) begin
                  if (bufw_ad_in[0]) r_line[1023:512] <= bufw_data_in;
                  else               r_line[511:0]    <= bufw_data_in;
                  r_half[bufw_ad_in[0]] <= 1'b1;
               end
               if (w_rsp_hit) begin
                  if (rsp_code_in == RSP_DONE) begin
                     if (w_have0 && w_have1) begin
                        r_state <= StReadData;
                     end else begin
                        r_error      <= 1'b1;
                        r_error_code <= 8'hFE;
                        r_busy       <= 1'b0;
                        r_state      <= StDoneReq;
                     end
                  end else if (w_retryable && r_retries < RT_MAX) begin
                     r_retries   <= r_retries + RT_W'(1);
                     r_half      <= '0;
                     r_cmd_valid <= 1'b1;
                     r_state     <= StReq;
                  end else begin
                     r_error      <= 1'b1;
                     r_error_code <= rsp_code_in;
                     r_busy       <= 1'b0;
                     r_state      <= StDoneReq;
                  end
               end else if (r_timeout == TO_LAST) begin
                  r_error      <= 1'b1;
                  r_error_code <= 8'hFF;
                  r_busy       <= 1'b0;
                  r_state      <= StDoneReq;
               end else begin
                  r_timeout <= r_timeout + TO_W'(1);
               end
            end
            StReadData: begin
               r_wed         <= w_swapped;
               r_wed_valid   <= 1'b1;
               r_wed_address <= r_addr;
               r_busy        <= 1'b0;
               r_state       <= StDoneReq;
            end
            StDoneReq: r_state <= StDoneReq;
            default:   r_state <= StIdle;
         endcase
      end
   end

endmodule
